maze_constraint_loader: RTL and testbench

Writes the per-cell down-constraint map that the collision checkers consume. On a start pulse the block reads one maze row per cycle from a synchronous level ROM and fills a registered `down_constraint` array (`size_y` rows × `size_x` columns). It raises `map_valid` once every row is written. The block sits between the level ROM and the deny-down checkers, and is re-run on every level change.

---
 rtl/maze_constraint_loader.sv | 129 ++++++++++++
 tb/tb_maze_constraint_loader.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/maze_constraint_loader.sv
// Loads the per-cell down-constraint map from the level ROM, one row per cycle.
// Build option: define MAZE_LOADER_FLOOR_EN to force the bottom row solid.
module maze_constraint_loader #(
  parameter int size_y = 20,
  parameter int size_x = 40,
  parameter int ROM_AW = 10
) (
  input  logic                Clk,
  input  logic                Reset_n,
  input  logic                start,
  input  logic [3:0]          level,
  output logic [ROM_AW-1:0]   rom_addr,
  output logic                rom_rd,
  input  logic [size_x-1:0]   rom_data,
  output logic [0:size_x-1]   down_constraint [size_y-1:0],
  output logic                busy,
  output logic                done,
  output logic                map_valid,
  output logic [1:0]          state_dbg
);

  // Handshake: start is a level request, accepted only in IDLE (never while
  // busy or in the done cycle); the ROM answers rom_rd with rom_data exactly
  // one cycle later, with no back-pressure in either direction.

  localparam int ROW_W = (size_y > 1) ? $clog2(size_y) : 1;
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(size_y - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    FIN   = 2'd3
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [3:0]        lvl_q;
  logic [ROW_W-1:0]  row;
  logic [ROW_W-1:0]  row_d;
  logic              wr_v;
  logic              accept;
  logic              last_issue;
  logic [ROM_AW-1:0] addr_nxt;
  logic [size_x-1:0] row_word;

  always_comb begin
    state_nxt  = state;
    accept     = 1'b0;
    last_issue = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = READ;
        end
      end
      READ: begin
        if (row == LAST_ROW) begin
          last_issue = 1'b1;
          state_nxt  = DRAIN;
        end
      end
      DRAIN:   state_nxt = FIN;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Address is formed at full width and only truncated to the ROM bus here.
  always_comb begin
    if (accept) begin
      addr_nxt = ROM_AW'(32'(level) * 32'(size_y));
    end else begin
      addr_nxt = ROM_AW'(32'(lvl_q) * 32'(size_y) + 32'(row) + 32'd1);
    end
  end

  assign rom_rd    = (state == READ);
  assign busy      = (state == READ) || (state == DRAIN);
  assign done      = (state == FIN);
  assign state_dbg = state;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state     <= IDLE;
      lvl_q     <= '0;
      row       <= '0;
      row_d     <= '0;
      wr_v      <= 1'b0;
      rom_addr  <= '0;
      map_valid <= 1'b0;
    end else begin
      state <= state_nxt;
      wr_v  <= rom_rd;
      row_d <= row;
      if (accept) begin
        lvl_q     <= level;
        row       <= '0;
        rom_addr  <= addr_nxt;
        map_valid <= 1'b0;
      end else if ((state == READ) && !last_issue) begin
        row      <= row + ROW_W'(1);
        rom_addr <= addr_nxt;
      end
      if (state == DRAIN) begin
        map_valid <= 1'b1;
      end
    end
  end

`ifdef MAZE_LOADER_FLOOR_EN
  assign row_word = (row_d == LAST_ROW) ? '1 : rom_data;
`else
  assign row_word = rom_data;
`endif

  // Rows stay stale until rewritten; the map is only trusted once map_valid rises.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < size_y; i++) begin
        down_constraint[i] <= '0;
      end
    end else if (wr_v) begin
      down_constraint[row_d] <= row_word;
    end
  end

endmodule

// File: tb/tb_maze_constraint_loader.sv
// Bench for maze_constraint_loader: vector table, corner sequences, random loads.
module tb_maze_constraint_loader;

  localparam int SY = 20;
  localparam int SX = 40;
  localparam int AW = 10;
`ifdef MAZE_LOADER_FLOOR_EN
  localparam bit FLOOR_EN = 1'b1;
`else
  localparam bit FLOOR_EN = 1'b0;
`endif

  logic          Clk = 1'b0;
  logic          Reset_n = 1'b0;
  logic          start = 1'b0;
  logic [3:0]    level = 4'd0;
  logic [AW-1:0] rom_addr;
  logic          rom_rd;
  logic [SX-1:0] rom_data = '0;
  logic [0:SX-1] down_constraint [SY-1:0];
  logic          busy;
  logic          done;
  logic          map_valid;
  logic [1:0]    state_dbg;

  logic [SX-1:0] rom_mem [1<<AW];
  logic [AW-1:0] exp_q [$];
  int            n_cmp = 0;
  int            n_err = 0;

  maze_constraint_loader #(.size_y(SY), .size_x(SX), .ROM_AW(AW)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .start(start), .level(level),
    .rom_addr(rom_addr), .rom_rd(rom_rd), .rom_data(rom_data),
    .down_constraint(down_constraint), .busy(busy), .done(done),
    .map_valid(map_valid), .state_dbg(state_dbg)
  );

  // Clock / ROM model
  always #5 Clk = ~Clk;
  always @(posedge Clk) if (rom_rd) rom_data <= rom_mem[rom_addr];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Reference: row r of level L is ROM word (L*rows + r) mod ROM depth.
  function automatic logic [SX-1:0] model_row(input logic [3:0] lvl, input int r);
    int a;
    a = (int'(lvl) * SY + r) % (1 << AW);
    if (FLOOR_EN && r == SY - 1) return '1;
    return rom_mem[a];
  endfunction

  function automatic bit map_is_zero();
    for (int r = 0; r < SY; r++) if (down_constraint[r] !== '0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic fill_pattern();
    logic [AW-1:0] av;
    for (int a = 0; a < (1 << AW); a++) begin
      av = AW'(a);
      rom_mem[a] = {av[7:0], 32'b0};
    end
  endtask

  // Driver: one-cycle start, then 30 cycles of monitoring against the model.
  task automatic load_and_check(input logic [3:0] lvl, input int repulse_k,
                                output logic [AW-1:0] first_addr,
                                output logic [AW-1:0] last_addr, output int done_k);
    int n_rd;
    int n_done;
    bit busy_bad;
    bit rd_bad;
    logic [AW-1:0] ea;
    exp_q.delete();
    for (int r = 0; r < SY; r++) exp_q.push_back(AW'(int'(lvl) * SY + r));
    level = lvl;
    start = 1'b1;
    @(negedge Clk);
    start = 1'b0;
    n_rd = 0; n_done = 0; done_k = -1; busy_bad = 0; rd_bad = 0;
    first_addr = '0; last_addr = '0;
    for (int k = 1; k <= 30; k++) begin
      if (busy !== (k <= SY + 1)) busy_bad = 1'b1;
      if (rom_rd) begin
        if (n_rd == 0) first_addr = rom_addr;
        last_addr = rom_addr;
        if (k != n_rd + 1) rd_bad = 1'b1;
        if (exp_q.size() == 0) rd_bad = 1'b1;
        else begin
          ea = exp_q.pop_front();
          check("rom_addr", 64'(rom_addr), 64'(ea));
        end
        n_rd++;
      end
      if (done) begin
        n_done++;
        if (done_k < 0) done_k = k;
      end
      if (k == 1) check("map_valid_cleared", 64'(map_valid), 64'(0));
      if (k == SY + 2) check("map_valid_set", 64'(map_valid), 64'(1));
      if (k == repulse_k) begin
        start = 1'b1;
        level = 4'd7;
      end else if (repulse_k > 0 && k == repulse_k + 1) begin
        start = 1'b0;
      end
      @(negedge Clk);
    end
    check("busy_window", 64'(busy_bad), 64'(0));
    check("rom_rd_timing", 64'(rd_bad), 64'(0));
    check("rom_rd_count", 64'(n_rd), 64'(SY));
    check("done_count", 64'(n_done), 64'(1));
    check("exp_q_empty", 64'(exp_q.size()), 64'(0));
    for (int r = 0; r < SY; r++) check($sformatf("row%0d", r), 64'(down_constraint[r]), 64'(model_row(lvl, r)));
  endtask

  typedef struct {
    logic [3:0]    level;
    int            repulse_k;
    logic [AW-1:0] first_addr;
    logic [AW-1:0] last_addr;
    int            latency;
  } vec_t;

  initial begin
    vec_t vecs [5];
    logic [AW-1:0] fa;
    logic [AW-1:0] la;
    int dk;
    int done_ks [$];
    bit bad;
    logic [3:0] rl;

    vecs[0] = '{4'd2,  0, 10'd40,  10'd59,  22};
    vecs[1] = '{4'd2,  5, 10'd40,  10'd59,  22};
    vecs[2] = '{4'd0,  0, 10'd0,   10'd19,  22};
    vecs[3] = '{4'd15, 0, 10'd300, 10'd319, 22};
    vecs[4] = '{4'd7,  0, 10'd140, 10'd159, 22};

    // Reset and idle
    fill_pattern();
    Reset_n = 1'b0;
    repeat (3) @(negedge Clk);
    Reset_n = 1'b1;
    @(negedge Clk);
    check("rst_rom_addr", 64'(rom_addr), 64'(0));
    check("rst_rom_rd", 64'(rom_rd), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_map_valid", 64'(map_valid), 64'(0));
    bad = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (busy !== 1'b0 || done !== 1'b0 || rom_rd !== 1'b0 || map_valid !== 1'b0) bad = 1'b1;
      if (!map_is_zero()) bad = 1'b1;
      @(negedge Clk);
    end
    check("idle_50_cycles", 64'(bad), 64'(0));

    // Vector table
    for (int i = 0; i < 5; i++) begin
      load_and_check(vecs[i].level, vecs[i].repulse_k, fa, la, dk);
      check($sformatf("vec%0d_first_addr", i), 64'(fa), 64'(vecs[i].first_addr));
      check($sformatf("vec%0d_last_addr", i), 64'(la), 64'(vecs[i].last_addr));
      check($sformatf("vec%0d_latency", i), 64'(dk), 64'(vecs[i].latency));
    end

    // start held high for 60 cycles: reload on every return to IDLE
    level = 4'd3;
    start = 1'b1;
    @(negedge Clk);
    for (int k = 1; k <= 75; k++) begin
      if (done) done_ks.push_back(k);
      if (k == SY + 3) check("held_map_valid_T23", 64'(map_valid), 64'(1));
      if (k == SY + 4) check("held_map_valid_T24", 64'(map_valid), 64'(0));
      if (k == 59) start = 1'b0;
      @(negedge Clk);
    end
    check("held_done_count", 64'(done_ks.size()), 64'(3));
    if (done_ks.size() >= 2) begin
      check("held_done_first", 64'(done_ks[0]), 64'(22));
      check("held_done_second", 64'(done_ks[1]), 64'(45));
    end
    for (int r = 0; r < SY; r++) check($sformatf("held_row%0d", r), 64'(down_constraint[r]), 64'(model_row(4'd3, r)));

    // Reset mid-load
    level = 4'd5;
    start = 1'b1;
    @(negedge Clk);
    start = 1'b0;
    repeat (9) @(negedge Clk);
    Reset_n = 1'b0;
    #1;
    check("arst_busy", 64'(busy), 64'(0));
    check("arst_rom_rd", 64'(rom_rd), 64'(0));
    check("arst_rom_addr", 64'(rom_addr), 64'(0));
    check("arst_done", 64'(done), 64'(0));
    check("arst_map_valid", 64'(map_valid), 64'(0));
    check("arst_map_zero", 64'(map_is_zero()), 64'(1));
    @(negedge Clk);
    Reset_n = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (done !== 1'b0 || busy !== 1'b0) bad = 1'b1;
      @(negedge Clk);
    end
    check("post_reset_quiet", 64'(bad), 64'(0));
    load_and_check(4'd5, 0, fa, la, dk);
    check("post_reset_latency", 64'(dk), 64'(22));

    // Random ROM contents and levels
    for (int a = 0; a < (1 << AW); a++) rom_mem[a] = SX'({$urandom(), $urandom()});
    for (int i = 0; i < 8; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge Clk);
      rl = 4'($urandom_range(0, 15));
      load_and_check(rl, (i % 3 == 0) ? int'($urandom_range(2, 18)) : 0, fa, la, dk);
      check("rand_latency", 64'(dk), 64'(22));
    end

    // All-zero ROM: only the optional floor row may be set
    for (int a = 0; a < (1 << AW); a++) rom_mem[a] = '0;
    load_and_check(4'($urandom_range(0, 15)), 0, fa, la, dk);
    check("floor_row", 64'(down_constraint[SY-1]), FLOOR_EN ? 64'({SX{1'b1}}) : 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
